// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding the architectural HI/LO pair.
// One start pulse launches a WIDTH-cycle shift-add or restoring shift-subtract, then a sign-fix cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Handshake: i_start is a request accepted only when the FSM is in IDLE (o_busy low);
  // there is no queue, so a request raised while busy is simply lost.
  logic w_accept;
  assign w_accept = (r_state == S_IDLE) && i_start;

  logic             w_in_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_in_signed = ~i_op[0];
  assign w_a_neg     = w_in_signed & i_a[WIDTH-1];
  assign w_b_neg     = w_in_signed & i_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -i_a : i_a;
  assign w_b_mag     = w_b_neg ? -i_b : i_b;

  logic w_is_div;
  logic w_signed;
  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];

  // Multiply: r_acc = {partial high, multiplier bits not yet consumed}, r_opnd = multiplicand.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend/quotient}, r_opnd = divisor.
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div0;
  assign w_prod = (w_signed & (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
  assign w_quo  = (w_signed & (r_sign_a ^ r_sign_b)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = (w_signed & r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  // With a zero divisor every step subtracts nothing, so the remainder ends as |a|
  // and the sign fix above restores a; only LO needs forcing.
  assign w_div0 = (r_opnd == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_CNT) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= i_op;
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_cnt    <= '0;
            r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
          end else begin
            if (i_mthi) r_hi <= i_a;
            if (i_mtlo) r_lo <= i_a;
          end
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_div0 ? {WIDTH{1'b1}} : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_state = r_state;

endmodule
